// File: rtl/fifo_stream_reader.sv
// Drains a standard-mode sync FIFO into a framed valid/ready stream through a 2-entry credit-managed skid buffer.
// Optional stall/starve statistics are compiled in with FIFO_STREAM_READER_STATS_EN.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 16,
  parameter int CNT_WIDTH  = 16,
  localparam int BW        = $clog2(PKT_LEN) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic                  fifo_valid,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [BW-1:0]         beat_count,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic                  busy,
`ifdef FIFO_STREAM_READER_STATS_EN
  output logic [31:0]           stall_count,
  output logic [31:0]           starve_count,
`endif
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    STOPPED  = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] buf_mem [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            occ;
  logic [1:0]            occ_after;
  logic                  inflight;
  logic                  overflow;
  logic                  pop, push_ok;
  logic                  last_beat;
  logic                  credit_ok, finish_ok, drained_after;
  logic [BW:0]           level, remaining;

  // Handshake: a beat transfers on a rising edge where m_tvalid and m_tready are both high;
  // m_tvalid/m_tdata never change while a beat waits for m_tready.
  always_comb begin
    pop       = (occ != 2'd0) & m_tready;
    push_ok   = fifo_valid & ((occ != 2'd2) | pop);
    occ_after = occ + {1'b0, push_ok} - {1'b0, pop};
    last_beat = (beat_count == BW'(PKT_LEN - 1));
    m_tvalid  = (occ != 2'd0);
    m_tdata   = m_tvalid ? buf_mem[rd_ptr] : '0;
    m_tlast   = m_tvalid & last_beat;
    busy      = (state != STOPPED);
    dbg_state = state;
    level     = (BW+1)'(occ) + (BW+1)'(inflight);
    remaining = (BW+1)'(PKT_LEN) - (BW+1)'(beat_count);
    // Every issued read must find a slot: held + in flight, less what leaves now, stays below 2.
    credit_ok = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
    // While winding down, fetch only what the current packet still needs.
    finish_ok = level < remaining;
  end

  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    case (state)
      STOPPED: begin
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (enable) begin
          fifo_rd_en = 1'b1;
        end else if (beat_count != '0) begin
          fifo_rd_en = finish_ok;
        end
      end
      STOPPING: begin
        fifo_rd_en = finish_ok;
      end
      default: state_nxt = STOPPED;
    endcase
    fifo_rd_en    = fifo_rd_en & credit_ok & ~fifo_empty & ~reset;
    drained_after = (occ_after == 2'd0) & ~fifo_rd_en;
    case (state)
      RUN: begin
        if (!enable) begin
          if (beat_count != '0) begin
            if (pop && last_beat) begin
              if (drained_after) state_nxt = STOPPED;
            end else begin
              state_nxt = STOPPING;
            end
          end else if (occ == 2'd0 && !inflight) begin
            state_nxt = STOPPED;
          end
        end
      end
      STOPPING: begin
        if (enable) begin
          state_nxt = RUN;
        end else if (pop && last_beat && drained_after) begin
          state_nxt = STOPPED;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= STOPPED;
      occ        <= 2'd0;
      inflight   <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      beat_count <= '0;
      pkt_count  <= '0;
      overflow   <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_rd_en;
      occ      <= occ_after;
      if (push_ok) begin
        buf_mem[wr_ptr] <= fifo_dout;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (fifo_valid && !push_ok) overflow <= 1'b1;
      if (pop) begin
        if (last_beat) begin
          beat_count <= '0;
          pkt_count  <= pkt_count + 1'b1;
        end else begin
          beat_count <= beat_count + 1'b1;
        end
      end
    end
  end

`ifdef FIFO_STREAM_READER_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count  <= '0;
      starve_count <= '0;
    end else begin
      if (m_tvalid && !m_tready && stall_count != 32'hFFFF_FFFF)
        stall_count <= stall_count + 32'd1;
      if (state == RUN && occ == 2'd0 && fifo_empty && starve_count != 32'hFFFF_FFFF)
        starve_count <= starve_count + 32'd1;
    end
  end
`endif

  // Sticky overflow can only set if the FIFO returns data that was never requested.
  no_overflow: assert property (@(posedge clock) disable iff (reset) !overflow);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: behavioural FIFO, scoreboard queue and negedge stream monitor.
`timescale 1ns/1ps
module tb_fifo_stream_reader;
  localparam int DW = 8;
  localparam int PL = 4;
  localparam int CW = 4;
  localparam int BW = $clog2(PL) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_valid = 1'b0;
  logic [DW-1:0] fifo_dout = '0;
  logic          m_tready = 1'b0;
  logic          fifo_rd_en, m_tvalid, m_tlast, busy;
  logic [DW-1:0] m_tdata;
  logic [BW-1:0] beat_count;
  logic [CW-1:0] pkt_count;
  logic [1:0]    dbg_state;
`ifdef FIFO_STREAM_READER_STATS_EN
  logic [31:0]   stall_count, starve_count;
`endif

  // clock / reset
  always #5 clock = ~clock;

  fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(PL), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_valid(fifo_valid), .fifo_dout(fifo_dout),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .beat_count(beat_count), .pkt_count(pkt_count), .busy(busy),
`ifdef FIFO_STREAM_READER_STATS_EN
    .stall_count(stall_count), .starve_count(starve_count),
`endif
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mem_q[$];
  logic [DW-1:0] exp_q[$];
  logic rd_req = 1'b0;
  logic vpulse = 1'b0;
  int tb_occ = 0, tb_infl = 0, exp_beat = 0, exp_pkt = 0, hs_count = 0;
  logic hold_v = 1'b0;
  logic [DW-1:0] hold_d = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // behavioural standard-read-mode FIFO: data one cycle after rd_en
  always @(posedge clock) begin
    #1;
    if (rd_req && mem_q.size() != 0) begin
      fifo_valid = 1'b1;
      fifo_dout  = mem_q.pop_front();
    end else if (vpulse) begin
      fifo_valid = ~fifo_valid;
      fifo_dout  = 8'hAA;
    end else begin
      fifo_valid = 1'b0;
    end
    fifo_empty = (mem_q.size() == 0);
  end
  always @(negedge clock) rd_req = fifo_rd_en;

  // stream monitor + scoreboard
  always @(negedge clock) begin
    int pop;
    logic [DW-1:0] e;
    if (reset) begin
      tb_occ = 0; tb_infl = 0; exp_beat = 0; exp_pkt = 0; hold_v = 1'b0;
    end else begin
      pop = (m_tvalid && m_tready) ? 1 : 0;
      check("tvalid_vs_occ", m_tvalid, tb_occ != 0);
      check("beat_count", beat_count, exp_beat);
      check("pkt_count", pkt_count, exp_pkt);
      if (fifo_rd_en) check("credit", (tb_occ + tb_infl - pop) < 2, 1);
      if (hold_v) begin
        check("stall_valid", m_tvalid, 1);
        check("stall_data", m_tdata, hold_d);
      end
      if (pop == 1) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("tdata", m_tdata, e);
        end
        check("tlast", m_tlast, exp_beat == PL - 1);
        if (exp_beat == PL - 1) begin
          exp_beat = 0;
          exp_pkt  = (exp_pkt + 1) % (1 << CW);
        end else begin
          exp_beat++;
        end
        hs_count++;
      end
      tb_occ  = tb_occ + (fifo_valid ? 1 : 0) - pop;
      tb_infl = fifo_rd_en ? 1 : 0;
      check("occ_le_2", tb_occ <= 2, 1);
      hold_v = m_tvalid && !m_tready;
      hold_d = m_tdata;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic load(input logic [DW-1:0] d);
    mem_q.push_back(d);
    exp_q.push_back(d);
  endtask

  task automatic wait_hs(input int target, input int budget);
    int n;
    n = 0;
    while (hs_count < target && n < budget) begin
      step();
      n++;
    end
    if (hs_count < target) check("hs_timeout", hs_count, target);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_tvalid"}, m_tvalid, 0);
    check({tag, "_tdata"}, m_tdata, 0);
    check({tag, "_tlast"}, m_tlast, 0);
    check({tag, "_beat"}, beat_count, 0);
    check({tag, "_pkt"}, pkt_count, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rd_en"}, fifo_rd_en, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_n, rd_first, rd_last, v_n, v_first, v_last, base, drop;

    // reset / idle with fifo_valid pulsing
    reset = 1'b1; vpulse = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("rst_tvalid", m_tvalid, 0);
      check("rst_busy", busy, 0);
    end
    vpulse = 1'b0;
    step();
    reset = 1'b0;
    step();
    check_zero_outputs("idle");
`ifdef FIFO_STREAM_READER_STATS_EN
    check("idle_stall", stall_count, 0);
    check("idle_starve", starve_count, 0);
`endif

    // streaming 0x01..0x08
    for (int i = 1; i <= 8; i++) load(DW'(i));
    m_tready = 1'b1; enable = 1'b1;
    rd_n = 0; rd_first = -1; rd_last = -1; v_n = 0; v_first = -1; v_last = -1;
    for (int c = 0; c < 16; c++) begin
      step();
      if (fifo_rd_en) begin rd_n++; if (rd_first < 0) rd_first = c; rd_last = c; end
      if (m_tvalid) begin v_n++; if (v_first < 0) v_first = c; v_last = c; end
    end
    check("stream_rd_n", rd_n, 8);
    check("stream_rd_span", rd_last - rd_first + 1, 8);
    check("stream_v_n", v_n, 8);
    check("stream_v_span", v_last - v_first + 1, 8);
    check("first_beat_lat", v_first - rd_first, 2);
    check("stream_pkts", pkt_count, 2);
    check("stream_hs", hs_count, 8);

    // backpressure 1,0,0,1 over 0x09..0x10
    for (int i = 9; i <= 16; i++) load(DW'(i));
    for (int k = 0; k < 40; k++) begin
      m_tready = (k % 4 == 0 || k % 4 == 3);
      step();
    end
    m_tready = 1'b1;
    wait_hs(16, 20);
    check("bp_pkts", pkt_count, 4);
    check("bp_sb_empty", exp_q.size(), 0);

    // starvation after beat 2
    load(8'h21); load(8'h22);
    wait_hs(18, 20);
    for (int c = 0; c < 10; c++) begin
      step();
      check("starve_tvalid", m_tvalid, 0);
      check("starve_beat", beat_count, 2);
    end
    load(8'h23); load(8'h24);
    wait_hs(20, 20);
    step();
    check("starve_pkts", pkt_count, 5);
    check("starve_beat_end", beat_count, 0);

    // graceful stop after beat 1 of the third packet
    base = hs_count;
    for (int i = 0; i < 16; i++) load(DW'(8'h31 + i));
    wait_hs(base + 9, 40);
    enable = 1'b0;
    wait_hs(base + 12, 40);
    for (int c = 0; c < 6; c++) begin
      step();
      check("stop_rd_en", fifo_rd_en, 0);
    end
    check("stop_busy", busy, 0);
    check("stop_state", dbg_state, 0);
    check("stop_pkts", pkt_count, 8);
    check("stop_hs", hs_count, base + 12);
    check("stop_fifo_left", mem_q.size(), 4);

    // mid-operation reset during beat 2 with a full skid buffer
    for (int i = 0; i < 8; i++) load(DW'(8'h41 + i));
    base = hs_count;
    enable = 1'b1; m_tready = 1'b1;
    wait_hs(base + 2, 40);
    m_tready = 1'b0;
    repeat (4) step();
    check("pre_rst_tvalid", m_tvalid, 1);
    check("pre_rst_beat", beat_count, 2);
    check("pre_rst_occ", tb_occ, 2);
    reset = 1'b1;
    step();
    check_zero_outputs("midrst");
`ifdef FIFO_STREAM_READER_STATS_EN
    check("midrst_stall", stall_count, 0);
`endif
    reset = 1'b0; enable = 1'b0;
    repeat (3) step();
    drop = exp_q.size() - mem_q.size();
    check("midrst_lost", drop, 2);
    for (int i = 0; i < drop; i++) void'(exp_q.pop_front());

    // 17 packets from reset: pkt_count wraps through zero
    for (int i = 0; i < 60; i++) load(DW'($urandom_range(0, 255)));
    base = hs_count;
    m_tready = 1'b1; enable = 1'b1;
    wait_hs(base + 68, 200);
    repeat (3) step();
    check("wrap_pkts", pkt_count, 1);
    check("wrap_beat", beat_count, 0);
    check("wrap_sb_empty", exp_q.size(), 0);
    check("overflow_flag", dut.overflow, 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Drain stage placed directly downstream of sync_fifo (Standard read mode).
- Turns the FIFO read port (rd_en / valid / dout / empty) into a valid/ready stream with packet framing (m_tlast every PKT_LEN beats).
- A 2-entry skid buffer with read credits keeps full throughput under backpressure while never overrunning the buffer.
- Feeds downstream packet consumers such as framers and DMA writers.

Parameters:
- DATA_WIDTH, 8, width of fifo_dout and m_tdata; matches the FIFO OUTPUT_WIDTH.
- PKT_LEN, 16, beats per packet (>=1); sets m_tlast spacing.
- CNT_WIDTH, 16, width of pkt_count.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run request; a drop stops the block at the next packet boundary.
- fifo_empty  in  1  empty flag from the FIFO.
- fifo_rd_en  out  1  read strobe to the FIFO.
- fifo_valid  in  1  FIFO data-valid strobe; data returns 1 cycle after fifo_rd_en.
- fifo_dout  in  DATA_WIDTH  FIFO read data.
- m_tdata  out  DATA_WIDTH  stream data.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tlast  out  1  last beat of a packet.
- beat_count  out  $clog2(PKT_LEN)+1  beat index within the current packet.
- pkt_count  out  CNT_WIDTH  completed packets; wraps modulo 2^CNT_WIDTH.
- busy  out  1  high while state != STOPPED.

Behaviour:
- Reset (synchronous, reset=1 at a clock edge):
  - Outputs: fifo_rd_en=0, m_tvalid=0, m_tdata=0, m_tlast=0, beat_count=0, pkt_count=0, busy=0.
  - Internal: buffer occupancy=0, inflight=0, state=STOPPED.
  - A fifo_valid that arrives in a cycle where reset=1 is discarded.
- Skid buffer:
  - 2 entries, FIFO-ordered; occ in 0..2.
  - Write: fifo_valid=1 pushes fifo_dout.
  - Read: a handshake (m_tvalid & m_tready) pops the head.
  - A push and a pop in the same cycle leave occ unchanged.
- Credit:
  - inflight = registered fifo_rd_en (read latency exactly 1).
  - fifo_rd_en = (state==RUN) & ~fifo_empty & (occ + inflight - pop_this_cycle < 2).
  - fifo_rd_en is combinational from registered state and the inputs.
  - Sustained throughput: 1 beat/cycle when m_tready stays high and the FIFO stays non-empty.
- Output:
  - m_tvalid = (occ != 0); m_tdata = buffer head.
  - Once asserted, m_tvalid and m_tdata stay stable until the handshake.
  - First beat appears 2 cycles after enable rises with a non-empty FIFO (rd_en cycle, then valid/push cycle, then head visible).
- Framing:
  - beat_count increments on each handshake.
  - m_tlast = m_tvalid & (beat_count == PKT_LEN-1).
  - On a handshake with m_tlast: beat_count returns to 0 and pkt_count increments.
  - PKT_LEN=1: m_tlast is high on every beat.
- State machine:
  - STOPPED -> RUN when enable=1.
  - RUN -> STOPPING when enable=0 and beat_count != 0.
  - RUN -> STOPPED when enable=0, beat_count=0, occ=0 and inflight=0.
  - Otherwise, when enable=0 with beat_count=0 but data still buffered or inflight, RUN stays in RUN, stops issuing reads, and drains until empty, then goes to STOPPED.
  - STOPPING: fifo_rd_en continues only as needed to finish the current packet.
    - Reads are limited so that occ + inflight never exceeds the remaining beats of the packet.
    - Exits to STOPPED on the m_tlast handshake, provided occ=0 and inflight=0 after the pop.
  - STOPPED: fifo_rd_en=0. Beats still buffered continue to drain.
  - enable re-asserted during STOPPING -> return to RUN.
- Boundary conditions:
  - FIFO empties mid-packet: m_tvalid drops; beat_count is held; the packet resumes when data arrives. No padding, no timeout.
  - fifo_valid with occ=2 and no pop: protocol violation; data dropped; sticky internal overflow flag (simulation assertion). This cannot occur while the credit rule holds.
  - pkt_count wraps from 2^CNT_WIDTH-1 to 0.

Optional Feature:
- Macro: FIFO_STREAM_READER_STATS_EN.
- Defined:
  - Adds output stall_count (32 bits), reset to 0, saturating at 0xFFFF_FFFF.
  - Increments each cycle with m_tvalid=1 & m_tready=0.
  - Adds output starve_count (32 bits), same reset/saturation, incrementing each cycle with state==RUN & occ=0 & fifo_empty=1.
- Undefined: neither port nor its logic exists. All other behaviour is identical.

Test Plan (DATA_WIDTH=8, PKT_LEN=4):
- Reset/idle: hold reset 5 cycles with fifo_valid pulsing -> all outputs 0; no push; busy=0.
- Streaming: FIFO returns bytes 0x01..0x08, m_tready=1, enable=1 -> fifo_rd_en high 8 consecutive cycles; m_tdata 0x01..0x08 on consecutive cycles; m_tlast on 0x04 and 0x08; pkt_count=2.
- Backpressure: m_tready toggles 1,0,0,1,... over 8 beats -> no loss or duplication; m_tdata stable while stalled; occ never >2; fifo_rd_en never has occ+inflight>2.
- Starvation: fifo_empty=1 after beat 2 for 10 cycles -> m_tvalid=0; beat_count=2 held; resumes with beat 3; m_tlast on beat 4.
- Graceful stop: drop enable after beat 1 of packet 3 -> exactly 3 more beats read; m_tlast on the last; STOPPED; fifo_rd_en=0 afterwards; pkt_count=3.
- Mid-operation reset: assert reset during beat 2 with occ=2 -> next cycle all outputs 0, occ=0; the following packet starts at beat_count=0.
